command_queue: RTL and testbench

Parametrised host-to-GPU command path that replaces the fixed 16-bit command interface/buffer pair. It samples the asynchronous host strobe into the GPU clock domain and captures command/data word pairs into a DEPTH-entry FIFO. It presents them to the GPU through a registered valid/busy handshake. It also adds flush, overflow detection and a host-readable status word. The block sits between the host pins (chip select, output enable, command strobe, command/data buses) and the GPU command decoder.

---
 rtl/command_queue.sv | 123 ++++++++++++
 tb/tb_command_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_queue.sv
// Host-to-GPU command queue: synchronises the host write strobe, buffers command/data pairs
// in a FIFO and hands them to the GPU through a registered valid/busy output stage.
module command_queue #(
    parameter int unsigned          CMD_WIDTH   = 16,
    parameter int unsigned          DATA_WIDTH  = 16,
    parameter int unsigned          DEPTH       = 8,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [CMD_WIDTH-1:0] FLUSH_CMD   = 16'hFFFF,
    parameter logic [CMD_WIDTH-1:0] STATUS_CMD  = 16'hFFFE,
    localparam int unsigned         PTR_W       = $clog2(DEPTH),
    localparam int unsigned         LVL_W       = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chipSelect,
    input  logic                  outputEnable,
    input  logic                  commandClk,
    input  logic [CMD_WIDTH-1:0]  inputCommand,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [DATA_WIDTH-1:0] dataFromGpu,
    input  logic                  gpuBusy,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataOutEnable,
    output logic                  gpuValid,
    output logic [CMD_WIDTH-1:0]  gpuCommand,
    output logic [DATA_WIDTH-1:0] gpuData,
    output logic                  hostBusy,
    output logic                  overflow,
    output logic [LVL_W-1:0]      level
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   edgeQ;
    logic [PTR_W-1:0]       wrPtrQ, rdPtrQ;
    logic [LVL_W-1:0]       levelQ;
    logic                   gpuValidQ, overflowQ;
    logic [CMD_WIDTH-1:0]   gpuCommandQ;
    logic [DATA_WIDTH-1:0]  gpuDataQ;
    logic [CMD_WIDTH-1:0]   cmdMem  [DEPTH];
    logic [DATA_WIDTH-1:0]  dataMem [DEPTH];

    logic writeEvent, flushEvent, pushReq, full, empty, doPush, doPop;

    assign writeEvent = syncQ[SYNC_STAGES-1] & ~edgeQ & chipSelect;
    assign flushEvent = writeEvent && (inputCommand == FLUSH_CMD);
    assign pushReq    = writeEvent && (inputCommand != FLUSH_CMD);
    assign full       = (levelQ == LVL_W'(DEPTH));
    assign empty      = (levelQ == '0);
    assign doPush     = pushReq && !full;
    // Pop decision uses the registered level, so a fresh push never falls through.
    assign doPop      = (!gpuValidQ || !gpuBusy) && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncQ <= '0;
            edgeQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], commandClk};
            edgeQ <= syncQ[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            cmdMem[wrPtrQ]  <= inputCommand;
            dataMem[wrPtrQ] <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtrQ      <= '0;
            rdPtrQ      <= '0;
            levelQ      <= '0;
            gpuValidQ   <= 1'b0;
            gpuCommandQ <= '0;
            gpuDataQ    <= '0;
            overflowQ   <= 1'b0;
        end else if (flushEvent) begin
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            levelQ    <= '0;
            gpuValidQ <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtrQ <= wrPtrQ + PTR_W'(1);
            end
            if (pushReq && full) begin
                overflowQ <= 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   levelQ <= levelQ + LVL_W'(1);
                2'b01:   levelQ <= levelQ - LVL_W'(1);
                default: levelQ <= levelQ;
            endcase
            if (doPop) begin
                rdPtrQ      <= rdPtrQ + PTR_W'(1);
                gpuValidQ   <= 1'b1;
                gpuCommandQ <= cmdMem[rdPtrQ];
                gpuDataQ    <= dataMem[rdPtrQ];
            end else if (gpuValidQ && !gpuBusy) begin
                gpuValidQ <= 1'b0;
            end
        end
    end

    always_comb begin
        dataOut = dataFromGpu;
        if (inputCommand == STATUS_CMD) begin
            dataOut = DATA_WIDTH'({overflowQ, full, levelQ});
        end
    end

    assign dataOutEnable = chipSelect & outputEnable;
    assign gpuValid      = gpuValidQ;
    assign gpuCommand    = gpuCommandQ;
    assign gpuData       = gpuDataQ;
    assign hostBusy      = full;
    assign overflow      = overflowQ;
    assign level         = levelQ;

endmodule

// File: tb/tb_command_queue.sv
// Directed bench for command_queue (default parameters: 16-bit words, DEPTH=8, 2 sync stages).
module tb_command_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        chipSelect, outputEnable, commandClk, gpuBusy;
    logic [15:0] inputCommand, dataIn, dataFromGpu;
    logic [15:0] dataOut, gpuCommand, gpuData;
    logic        dataOutEnable, gpuValid, hostBusy, overflow;
    logic [3:0]  level;

    int checkCount = 0;
    int passCount  = 0;
    int holdErr    = 0;
    logic toggleBusy = 1'b0;
    logic [31:0] xfers[$];
    logic        prevValid = 1'b0, prevBusy = 1'b0;
    logic [15:0] prevCmd = '0, prevData = '0;

    always #5 clk = ~clk;

    command_queue dut (
        .clk          (clk),
        .rst          (rst),
        .chipSelect   (chipSelect),
        .outputEnable (outputEnable),
        .commandClk   (commandClk),
        .inputCommand (inputCommand),
        .dataIn       (dataIn),
        .dataFromGpu  (dataFromGpu),
        .gpuBusy      (gpuBusy),
        .dataOut      (dataOut),
        .dataOutEnable(dataOutEnable),
        .gpuValid     (gpuValid),
        .gpuCommand   (gpuCommand),
        .gpuData      (gpuData),
        .hostBusy     (hostBusy),
        .overflow     (overflow),
        .level        (level)
    );

    // Logs every completed transfer and counts held entries that changed while stalled.
    always @(posedge clk) begin
        if (rst) begin
            if (gpuValid && !gpuBusy) xfers.push_back({gpuCommand, gpuData});
            if (prevValid && prevBusy && (gpuCommand !== prevCmd || gpuData !== prevData))
                holdErr <= holdErr + 1;
        end
        prevValid <= gpuValid;
        prevBusy  <= gpuBusy;
        prevCmd   <= gpuCommand;
        prevData  <= gpuData;
    end

    task automatic tick();
        @(negedge clk);
        if (toggleBusy) gpuBusy = ~gpuBusy;
    endtask

    task automatic strobeHigh(input logic [15:0] cmd, input logic [15:0] data);
        chipSelect   = 1'b1;
        inputCommand = cmd;
        dataIn       = data;
        commandClk   = 1'b1;
    endtask

    task automatic hostWrite(input logic [15:0] cmd, input logic [15:0] data);
        strobeHigh(cmd, data);
        repeat (4) tick();
        commandClk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #2;
        checkCount++;
        if ({gpuValid, hostBusy, overflow, level, gpuCommand, gpuData} !== '0)
            $display("FAIL reset_outputs: got v=%b hb=%b ov=%b lvl=%0d cmd=%h data=%h, expected all 0",
                     gpuValid, hostBusy, overflow, level, gpuCommand, gpuData);
        else passCount++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        checkCount++;
        if (level !== 4'd0 || gpuValid !== 1'b0)
            $display("FAIL reset_release: got lvl=%0d v=%b, expected 0 0", level, gpuValid);
        else passCount++;
    endtask

    task automatic test_single_write();
        int base;
        base    = xfers.size();
        gpuBusy = 1'b0;
        strobeHigh(16'h0012, 16'hABCD);
        tick(); tick();
        checkCount++;
        if (level !== 4'd0) $display("FAIL single_level_pre: got %0d expected 0", level);
        else passCount++;
        tick();
        checkCount++;
        if (level !== 4'd1 || gpuValid !== 1'b0)
            $display("FAIL single_push: got lvl=%0d v=%b expected 1 0", level, gpuValid);
        else passCount++;
        tick();
        checkCount++;
        if (gpuValid !== 1'b1 || gpuCommand !== 16'h0012 || gpuData !== 16'hABCD || level !== 4'd0)
            $display("FAIL single_valid: got v=%b %h/%h lvl=%0d expected 1 0012/abcd 0",
                     gpuValid, gpuCommand, gpuData, level);
        else passCount++;
        commandClk = 1'b0;
        tick();
        checkCount++;
        if (gpuValid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL single_pulse_end: got v=%b ov=%b expected 0 0", gpuValid, overflow);
        else passCount++;
        repeat (3) tick();
        checkCount++;
        if (xfers.size() - base !== 1)
            $display("FAIL single_xfer_count: got %0d expected 1", xfers.size() - base);
        else passCount++;
    endtask

    task automatic test_overflow();
        int base;
        base    = xfers.size();
        gpuBusy = 1'b1;
        for (int i = 0; i < 9; i++) hostWrite(16'h0100 + 16'(i), 16'hD000 + 16'(i));
        checkCount++;
        if (level !== 4'd8 || hostBusy !== 1'b1 || overflow !== 1'b0)
            $display("FAIL ovf_full: got lvl=%0d hb=%b ov=%b expected 8 1 0", level, hostBusy, overflow);
        else passCount++;
        hostWrite(16'h0109, 16'hD009);
        checkCount++;
        if (overflow !== 1'b1 || level !== 4'd8)
            $display("FAIL ovf_drop: got ov=%b lvl=%0d expected 1 8", overflow, level);
        else passCount++;
        checkCount++;
        if (gpuValid !== 1'b1 || gpuCommand !== 16'h0100 || gpuData !== 16'hD000)
            $display("FAIL ovf_held: got v=%b %h/%h expected 1 0100/d000", gpuValid, gpuCommand, gpuData);
        else passCount++;
        checkCount++;
        if (xfers.size() !== base)
            $display("FAIL ovf_no_xfer_busy: got %0d expected 0", xfers.size() - base);
        else passCount++;
        gpuBusy = 1'b0;
        repeat (15) tick();
        checkCount++;
        if (xfers.size() - base !== 9)
            $display("FAIL ovf_xfer_count: got %0d expected 9", xfers.size() - base);
        else passCount++;
        for (int i = 0; i < 9; i++) begin
            if (base + i < xfers.size()) begin
                checkCount++;
                if (xfers[base + i] !== {16'h0100 + 16'(i), 16'hD000 + 16'(i)})
                    $display("FAIL ovf_order[%0d]: got %h expected %h", i, xfers[base + i],
                             {16'h0100 + 16'(i), 16'hD000 + 16'(i)});
                else passCount++;
            end
        end
        checkCount++;
        if (level !== 4'd0 || gpuValid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_drained: got lvl=%0d v=%b ov=%b expected 0 0 1", level, gpuValid, overflow);
        else passCount++;
    endtask

    task automatic test_status();
        gpuBusy = 1'b1;
        for (int i = 0; i < 4; i++) hostWrite(16'h0200 + 16'(i), 16'hE000 + 16'(i));
        checkCount++;
        if (level !== 4'd3 || overflow !== 1'b1)
            $display("FAIL status_pre: got lvl=%0d ov=%b expected 3 1", level, overflow);
        else passCount++;
        outputEnable = 1'b1;
        inputCommand = 16'hFFFE;
        #1;
        // {overflow, hostBusy, level[3:0]} = {1, 0, 0011}
        checkCount++;
        if (dataOut !== 16'h0023 || dataOutEnable !== 1'b1)
            $display("FAIL status_word: got %h oe=%b expected 0023 1", dataOut, dataOutEnable);
        else passCount++;
        inputCommand = 16'h1234;
        dataFromGpu  = 16'h5A5A;
        #1;
        checkCount++;
        if (dataOut !== 16'h5A5A) $display("FAIL readback_gpu: got %h expected 5a5a", dataOut);
        else passCount++;
        outputEnable = 1'b0;
        #1;
        checkCount++;
        if (dataOutEnable !== 1'b0) $display("FAIL readback_oe_off: got %b expected 0", dataOutEnable);
        else passCount++;
    endtask

    task automatic test_flush();
        int base;
        base = xfers.size();
        strobeHigh(16'hFFFF, 16'h0000);
        tick(); tick();
        checkCount++;
        if (gpuValid !== 1'b1 || level !== 4'd3)
            $display("FAIL flush_pre: got v=%b lvl=%0d expected 1 3", gpuValid, level);
        else passCount++;
        tick();
        checkCount++;
        if (gpuValid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || hostBusy !== 1'b0)
            $display("FAIL flush_clear: got v=%b lvl=%0d ov=%b hb=%b expected 0 0 0 0",
                     gpuValid, level, overflow, hostBusy);
        else passCount++;
        commandClk = 1'b0;
        gpuBusy    = 1'b0;
        repeat (10) tick();
        checkCount++;
        if (xfers.size() !== base || gpuValid !== 1'b0)
            $display("FAIL flush_no_xfer: got %0d xfers v=%b expected 0 0", xfers.size() - base, gpuValid);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int base, holdBase;
        base       = xfers.size();
        holdBase   = holdErr;
        gpuBusy    = 1'b0;
        toggleBusy = 1'b1;
        for (int i = 0; i < 6; i++) hostWrite(16'h0300 + 16'(i), 16'hC300 + 16'(i));
        repeat (10) tick();
        toggleBusy = 1'b0;
        gpuBusy    = 1'b0;
        repeat (3) tick();
        checkCount++;
        if (xfers.size() - base !== 6)
            $display("FAIL toggle_xfer_count: got %0d expected 6", xfers.size() - base);
        else passCount++;
        for (int i = 0; i < 6; i++) begin
            if (base + i < xfers.size()) begin
                checkCount++;
                if (xfers[base + i] !== {16'h0300 + 16'(i), 16'hC300 + 16'(i)})
                    $display("FAIL toggle_order[%0d]: got %h expected %h", i, xfers[base + i],
                             {16'h0300 + 16'(i), 16'hC300 + 16'(i)});
                else passCount++;
            end
        end
        checkCount++;
        if (holdErr !== holdBase)
            $display("FAIL toggle_hold: got %0d changes while busy expected 0", holdErr - holdBase);
        else passCount++;
    endtask

    task automatic test_reset_midstream();
        int base;
        base    = xfers.size();
        gpuBusy = 1'b1;
        for (int i = 0; i < 3; i++) hostWrite(16'h0400 + 16'(i), 16'hB400 + 16'(i));
        checkCount++;
        if (gpuValid !== 1'b1 || level !== 4'd2)
            $display("FAIL midrst_pre: got v=%b lvl=%0d expected 1 2", gpuValid, level);
        else passCount++;
        outputEnable = 1'b1;
        inputCommand = 16'hFFFE;
        #2;
        rst = 1'b0;
        #1;
        checkCount++;
        if ({gpuValid, hostBusy, overflow, level, gpuCommand, gpuData} !== '0 || dataOut !== 16'h0000)
            $display("FAIL midrst_async: got v=%b hb=%b ov=%b lvl=%0d cmd=%h data=%h dout=%h, expected all 0",
                     gpuValid, hostBusy, overflow, level, gpuCommand, gpuData, dataOut);
        else passCount++;
        @(negedge clk);
        rst          = 1'b1;
        gpuBusy      = 1'b0;
        outputEnable = 1'b0;
        repeat (6) tick();
        checkCount++;
        if (xfers.size() !== base || level !== 4'd0 || gpuValid !== 1'b0)
            $display("FAIL midrst_discard: got %0d xfers lvl=%0d v=%b expected 0 0 0",
                     xfers.size() - base, level, gpuValid);
        else passCount++;
    endtask

    initial begin
        rst          = 1'b0;
        chipSelect   = 1'b0;
        outputEnable = 1'b0;
        commandClk   = 1'b0;
        inputCommand = 16'h0000;
        dataIn       = 16'h0000;
        dataFromGpu  = 16'h0000;
        gpuBusy      = 1'b0;
        test_reset();
        test_single_write();
        test_overflow();
        test_status();
        test_flush();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
